// File: rtl/muldiv_seq_if.sv
// Handshake, result and shared-ALU signals of the multiply/divide sequencer.
// slave is the sequencer side; master is the controller and ALU side.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_zero;
    logic             alu_own;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_mode;
    logic             alu_carry_in;
    logic [WIDTH-1:0] alu_out;
    logic [7:0]       alu_flags;

    modport slave (
        input  start, op, opa, opb, alu_out, alu_flags,
        output busy, done, result_lo, result_hi, div_zero,
        output alu_own, alu_a, alu_b, alu_mode, alu_carry_in
    );

    modport master (
        output start, op, opa, opb, alu_out, alu_flags,
        input  busy, done, result_lo, result_hi, div_zero,
        input  alu_own, alu_a, alu_b, alu_mode, alu_carry_in
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential 16-bit unsigned MUL (shift-add) and DIV (restoring) that borrows the
// shared ALU for one add or subtract per cycle; shifting is done locally.
module muldiv_seq #(
    parameter int unsigned WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [3:0] ModeAdd = 4'b0000;
    localparam logic [3:0] ModeSub = 4'b0001;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic             r_op;
    logic [CntW-1:0]  r_cnt;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_hi_d;
    logic [WIDTH-1:0] w_lo_d;
    logic [WIDTH-1:0] w_m_d;
    logic             w_op_d;
    logic [CntW-1:0]  w_cnt_d;
    logic             w_div_zero_d;

    logic             w_accept;
    logic             w_start_dz;
    logic [WIDTH-1:0] w_trial;
    logic             w_shift_out;
    logic             w_alu_c;
    logic             w_ok;
    logic             w_unused_flags;

    assign w_accept    = bus.start && (r_state != StRun);
    assign w_start_dz  = bus.op && (bus.opb == '0);
    assign w_trial     = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_shift_out = r_hi[WIDTH-1];
    assign w_alu_c     = bus.alu_flags[1];
    // A set shifted-out bit means the 17-bit partial remainder already exceeds the divisor.
    assign w_ok        = w_shift_out | ~w_alu_c;

    assign w_unused_flags = ^{bus.alu_flags[7:2], bus.alu_flags[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_hi       <= '0;
            r_lo       <= '0;
            r_m        <= '0;
            r_op       <= 1'b0;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_hi       <= w_hi_d;
            r_lo       <= w_lo_d;
            r_m        <= w_m_d;
            r_op       <= w_op_d;
            r_cnt      <= w_cnt_d;
            r_div_zero <= w_div_zero_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_accept) begin
                    w_state_d = w_start_dz ? StDone : StRun;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StRun: begin
                if (r_cnt == CntLast) begin
                    w_state_d = StDone;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_hi_d       = r_hi;
        w_lo_d       = r_lo;
        w_m_d        = r_m;
        w_op_d       = r_op;
        w_cnt_d      = r_cnt;
        w_div_zero_d = r_div_zero;
        if (w_accept) begin
            if (w_start_dz) begin
                w_hi_d       = bus.opa;
                w_lo_d       = '1;
                w_div_zero_d = 1'b1;
            end else begin
                w_op_d       = bus.op;
                w_m_d        = bus.opb;
                w_hi_d       = '0;
                w_lo_d       = bus.opa;
                w_cnt_d      = '0;
                w_div_zero_d = 1'b0;
            end
        end else if (r_state == StRun) begin
            w_cnt_d = r_cnt + CntOne;
            if (!r_op) begin
                w_hi_d = {w_alu_c, bus.alu_out[WIDTH-1:1]};
                w_lo_d = {bus.alu_out[0], r_lo[WIDTH-1:1]};
            end else begin
                w_hi_d = w_ok ? bus.alu_out : w_trial;
                w_lo_d = {r_lo[WIDTH-2:0], w_ok};
            end
        end
    end

    always_comb begin
        bus.busy         = (r_state == StRun);
        bus.alu_own      = (r_state == StRun);
        bus.done         = (r_state == StDone);
        bus.result_lo    = r_lo;
        bus.result_hi    = r_hi;
        bus.div_zero     = r_div_zero;
        bus.alu_carry_in = 1'b0;
        bus.alu_a        = '0;
        bus.alu_b        = '0;
        bus.alu_mode     = ModeAdd;
        if (r_state == StRun) begin
            if (r_op) begin
                bus.alu_a    = w_trial;
                bus.alu_b    = r_m;
                bus.alu_mode = ModeSub;
            end else begin
                bus.alu_a = r_hi;
                bus.alu_b = r_lo[0] ? r_m : '0;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against an arithmetic reference
// (a*b, a/b, a%b) with a behavioural ADD/SUB ALU attached.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic [7:0]  flag_noise = 8'h00;
    logic [16:0] alu_sum;

    muldiv_seq_if #(.WIDTH(16)) bus ();

    muldiv_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU: flag bit 1 is carry on ADD and borrow on SUB; other bits are noise.
    always_comb begin
        alu_sum = 17'd0;
        case (bus.alu_mode)
            4'b0000: alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'b0001: alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            default: alu_sum = 17'd0;
        endcase
        bus.alu_out   = alu_sum[15:0];
        bus.alu_flags = (flag_noise & 8'hFD) | {6'd0, alu_sum[16], 1'b0};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic op, input logic [15:0] a,
                                               input logic [15:0] b);
        int unsigned ua;
        int unsigned ub;
        ua = 32'(a);
        ub = 32'(b);
        if (!op) return ua * ub;
        if (ub == 0) return {a, 16'hFFFF};
        return {16'(ua % ub), 16'(ua / ub)};
    endfunction

    // One operation; if glitch > 0, a stray start with junk operands is pulsed mid-RUN.
    task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input string tag, input int glitch);
        int          edges;
        int          run_cyc;
        int          bad;
        logic [31:0] exp;
        logic        exp_dz;
        exp    = ref_result(op, a, b);
        exp_dz = op && (b == 16'd0);
        flag_noise = 8'($urandom);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.opa   = 16'($urandom);
        bus.opb   = 16'($urandom);
        run_cyc = 0;
        bad     = 0;
        while (!bus.done && edges < 40) begin
            if (bus.busy) run_cyc++;
            if (bus.alu_own !== bus.busy) bad++;
            if (bus.busy && bus.alu_mode !== {3'b000, op}) bad++;
            if (bus.alu_carry_in !== 1'b0) bad++;
            bus.start = (glitch > 0 && edges == glitch);
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.start = 1'b0;
        end
        check_eq({tag, " latency"}, 32'(edges), exp_dz ? 32'd1 : 32'd17);
        check_eq({tag, " busy cycles"}, 32'(run_cyc), exp_dz ? 32'd0 : 32'd16);
        check_eq({tag, " alu drive errors"}, 32'(bad), 32'd0);
        check_eq({tag, " result"}, {bus.result_hi, bus.result_lo}, exp);
        check_eq({tag, " div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
        check_eq({tag, " idle alu"}, {bus.alu_own, bus.busy, bus.alu_mode, bus.alu_a, bus.alu_b[9:0]},
                 32'd0);
        @(negedge clk);
        check_eq({tag, " done pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, " result hold"}, {bus.result_hi, bus.result_lo}, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int       edges;
        int       done_seen;
        logic     rop;
        logic [15:0] ra;
        logic [15:0] rb;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.opa   = 16'h0;
        bus.opb   = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset outputs", {bus.busy, bus.done, bus.div_zero, bus.alu_own, bus.alu_carry_in,
                                   bus.alu_mode, bus.result_hi[10:0], bus.result_lo}, 32'd0);
        check_eq("reset alu ab", {bus.alu_a, bus.alu_b}, 32'd0);
        rst = 1'b0;

        run_op(1'b0, 16'h1234, 16'h5678, "mul 1234x5678", 0);
        check_eq("mul 1234x5678 const", {bus.result_hi, bus.result_lo}, 32'h0626_0060);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, "mul ffffxffff", 0);
        run_op(1'b0, 16'h0000, 16'hBEEF, "mul 0xbeef", 0);
        run_op(1'b1, 16'd1000, 16'd7, "div 1000/7", 0);
        check_eq("div 1000/7 const", {bus.result_hi, bus.result_lo}, 32'h0006_008E);
        run_op(1'b1, 16'hFFFF, 16'h0001, "div ffff/1", 0);
        run_op(1'b1, 16'h8000, 16'h8001, "div 8000/8001", 0);
        run_op(1'b1, 16'hFFFF, 16'h8000, "div ffff/8000", 0);
        run_op(1'b1, 16'h1234, 16'h0000, "div by zero", 0);
        run_op(1'b1, 16'd1000, 16'd7, "div after dz", 0);
        run_op(1'b1, 16'd1000, 16'd7, "start ignored in run", 5);

        // Reset asserted during the fifth RUN cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.opa   = 16'd1000;
        bus.opb   = 16'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("pre-reset busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid reset state", {bus.busy, bus.alu_own, bus.div_zero, bus.result_hi[12:0],
                                     bus.result_lo}, 32'd0);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check_eq("no done after reset", 32'(done_seen), 32'd0);
        run_op(1'b1, 16'd1000, 16'd7, "div after reset", 0);

        // Start held high through DONE chains a second operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.opa   = 16'h00FF;
        bus.opb   = 16'h0101;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.op  = 1'b1;
        bus.opa = 16'd1000;
        bus.opb = 16'd7;
        while (!bus.done && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_eq("b2b first latency", 32'(edges), 32'd17);
        check_eq("b2b first result", {bus.result_hi, bus.result_lo}, 32'h0000_FFFF);
        @(posedge clk);
        edges++;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("b2b second busy", 32'(bus.busy), 32'd1);
        while (!bus.done && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_eq("b2b second latency", 32'(edges), 32'd34);
        check_eq("b2b second result", {bus.result_hi, bus.result_lo}, 32'h0006_008E);

        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom);
            ra  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 16'h0000;
                1: rb = 16'($urandom_range(1, 15));
                2: rb = 16'hFFFF;
                default: rb = 16'($urandom);
            endcase
            run_op(rop, ra, rb, $sformatf("rand%0d %s %04h %04h", i, rop ? "div" : "mul", ra, rb),
                   (i % 5 == 0) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
